// File: rtl/id_ex_stage_reg_if.sv
// rtl/id_ex_stage_reg_if.sv - ID/EX stage bus: decoded fields, register-file reads, WB port, EX outputs
interface id_ex_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 16,
  parameter int CNT_W   = 16
);
  // ID-side decoded instruction
  logic               id_valid;
  logic [DATA_W-1:0]  id_pc;
  logic [RADDR_W-1:0] id_rs;
  logic [RADDR_W-1:0] id_rt;
  logic [RADDR_W-1:0] id_dst;
  logic               id_reg_write;
  logic [DATA_W-1:0]  id_imm;
  logic [CTRL_W-1:0]  id_ctrl;

  // register-file read data for id_rs / id_rt
  logic [DATA_W-1:0]  rf_rdata1;
  logic [DATA_W-1:0]  rf_rdata2;

  // WB write port, committed by the register file at the clock edge
  logic               wb_reg_write;
  logic [RADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0]  wb_wdata;

  // EX-side registered outputs
  logic               ex_valid;
  logic [DATA_W-1:0]  ex_pc;
  logic [DATA_W-1:0]  ex_imm;
  logic [RADDR_W-1:0] ex_rs;
  logic [RADDR_W-1:0] ex_rt;
  logic [RADDR_W-1:0] ex_dst;
  logic               ex_reg_write;
  logic [CTRL_W-1:0]  ex_ctrl;
  logic [DATA_W-1:0]  ex_rs_data;
  logic [DATA_W-1:0]  ex_rt_data;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output id_valid, id_pc, id_rs, id_rt, id_dst, id_reg_write, id_imm, id_ctrl,
    output rf_rdata1, rf_rdata2,
    output wb_reg_write, wb_waddr, wb_wdata,
    input  ex_valid, ex_pc, ex_imm, ex_rs, ex_rt, ex_dst, ex_reg_write, ex_ctrl,
    input  ex_rs_data, ex_rt_data, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs, id_rt, id_dst, id_reg_write, id_imm, id_ctrl,
    input  rf_rdata1, rf_rdata2,
    input  wb_reg_write, wb_waddr, wb_wdata,
    output ex_valid, ex_pc, ex_imm, ex_rs, ex_rt, ex_dst, ex_reg_write, ex_ctrl,
    output ex_rs_data, ex_rt_data, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID->EX pipeline register with stall, flush, WB bypass and bubble counter
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  id_ex_stage_reg_if.slave        bus
);

  logic               ex_valid_q,     ex_valid_d;
  logic [DATA_W-1:0]  ex_pc_q,        ex_pc_d;
  logic [DATA_W-1:0]  ex_imm_q,       ex_imm_d;
  logic [RADDR_W-1:0] ex_rs_q,        ex_rs_d;
  logic [RADDR_W-1:0] ex_rt_q,        ex_rt_d;
  logic [RADDR_W-1:0] ex_dst_q,       ex_dst_d;
  logic               ex_reg_write_q, ex_reg_write_d;
  logic [CTRL_W-1:0]  ex_ctrl_q,      ex_ctrl_d;
  logic [DATA_W-1:0]  ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_W-1:0]  ex_rt_data_q,   ex_rt_data_d;
  logic [CNT_W-1:0]   bubble_cnt_q,   bubble_cnt_d;

  logic               load_bubble;
  logic               bypass_rs;
  logic               bypass_rt;
  logic               refresh_rs;
  logic               refresh_rt;

  // Decide the action for this edge and whether WB data must replace a register-file operand
  always_comb begin
    load_bubble = flush || (!stall && !bus.id_valid);
    // The register file commits WB only at the edge, so its read data is one write behind
    bypass_rs   = bus.wb_reg_write && (bus.wb_waddr == bus.id_rs) && (bus.id_rs != '0);
    bypass_rt   = bus.wb_reg_write && (bus.wb_waddr == bus.id_rt) && (bus.id_rt != '0);
    // A WB commit during a hold would otherwise leave a stale operand in EX
    refresh_rs  = ex_valid_q && bus.wb_reg_write && (bus.wb_waddr == ex_rs_q) && (ex_rs_q != '0);
    refresh_rt  = ex_valid_q && bus.wb_reg_write && (bus.wb_waddr == ex_rt_q) && (ex_rt_q != '0);
  end

  // Next-state for every EX field: flush/bubble > stall (hold + refresh) > load
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_imm_d       = ex_imm_q;
    ex_rs_d        = ex_rs_q;
    ex_rt_d        = ex_rt_q;
    ex_dst_d       = ex_dst_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_rs_data_d   = ex_rs_data_q;
    ex_rt_data_d   = ex_rt_data_q;
    bubble_cnt_d   = bubble_cnt_q;

    if (load_bubble) begin
      ex_valid_d     = 1'b0;
      ex_pc_d        = '0;
      ex_imm_d       = '0;
      ex_rs_d        = '0;
      ex_rt_d        = '0;
      ex_dst_d       = '0;
      ex_reg_write_d = 1'b0;
      ex_ctrl_d      = '0;
      ex_rs_data_d   = '0;
      ex_rt_data_d   = '0;
      // Saturate rather than wrap so a long idle period never reads back as few bubbles
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (stall) begin
      if (refresh_rs) begin
        ex_rs_data_d = bus.wb_wdata;
      end
      if (refresh_rt) begin
        ex_rt_data_d = bus.wb_wdata;
      end
    end else begin
      ex_valid_d     = 1'b1;
      ex_pc_d        = bus.id_pc;
      ex_imm_d       = bus.id_imm;
      ex_rs_d        = bus.id_rs;
      ex_rt_d        = bus.id_rt;
      ex_dst_d       = bus.id_dst;
      ex_reg_write_d = bus.id_reg_write;
      ex_ctrl_d      = bus.id_ctrl;
      ex_rs_data_d   = bypass_rs ? bus.wb_wdata : bus.rf_rdata1;
      ex_rt_data_d   = bypass_rt ? bus.wb_wdata : bus.rf_rdata2;
    end
  end

  // EX state register, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_imm_q       <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dst_q       <= '0;
      ex_reg_write_q <= 1'b0;
      ex_ctrl_q      <= '0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_imm_q       <= ex_imm_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dst_q       <= ex_dst_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  // Outputs come straight from flops; no input reaches an output combinationally
  always_comb begin
    bus.ex_valid     = ex_valid_q;
    bus.ex_pc        = ex_pc_q;
    bus.ex_imm       = ex_imm_q;
    bus.ex_rs        = ex_rs_q;
    bus.ex_rt        = ex_rt_q;
    bus.ex_dst       = ex_dst_q;
    bus.ex_reg_write = ex_reg_write_q;
    bus.ex_ctrl      = ex_ctrl_q;
    bus.ex_rs_data   = ex_rs_data_q;
    bus.ex_rt_data   = ex_rt_data_q;
    bus.bubble_cnt   = bubble_cnt_q;
  end

endmodule
